// File: rtl/uart_tx_io_if.sv
// CPU-side IO bus of the UART transmitter: write/read strobes, chip select,
// register offset, write data and combinational status read data.
// master = CPU / IO decode side, slave = uart_tx_io.
//   uarttxwrite  IOWrite strobe
//   uarttxread   IORead strobe
//   uarttxcs     chip select from the address decoder
//   uarttxaddr   register offset (2 bits)
//   uarttxwdata  write data (16 bits)
//   uarttxrdata  status read data (16 bits), driven by the slave
interface uart_tx_io_if;
  logic        uarttxwrite;
  logic        uarttxread;
  logic        uarttxcs;
  logic [1:0]  uarttxaddr;
  logic [15:0] uarttxwdata;
  logic [15:0] uarttxrdata;

  modport master (
    output uarttxwrite,
    output uarttxread,
    output uarttxcs,
    output uarttxaddr,
    output uarttxwdata,
    input  uarttxrdata
  );

  modport slave (
    input  uarttxwrite,
    input  uarttxread,
    input  uarttxcs,
    input  uarttxaddr,
    input  uarttxwdata,
    output uarttxrdata
  );
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, plus the generic
// FIFO it is built on.
// uart_tx_io ports:
//   clock, reset   single clock, asynchronous active-high reset
//   bus            uart_tx_io_if.slave: write/read/cs/addr/wdata in, rdata out
//   tx             registered serial line, idles high
// Register map: 0 = DATA (push wdata[7:0]), 2 = CTRL (wdata[3] clears
// overflow) / STATUS read {count[7:0], 4'b0, overflow, busy, full, empty}.

// Generic synchronous FIFO, power-of-2 depth, pointers wrap naturally.
// Latency: a pushed entry is visible on pop_dat one edge after the push.
// Backpressure: push_rdy low when full (push dropped); pop_vld low when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_fire, pop_fire;

  // Readiness depends only on the occupancy before the edge, so a push into
  // a full FIFO is refused even when a pop happens on the same edge.
  assign push_rdy  = (cnt_q != CW'(DEPTH));
  assign pop_vld   = (cnt_q != '0);
  assign push_fire = push_vld & push_rdy;
  assign pop_fire  = pop_vld & pop_rdy;
  assign pop_dat   = mem_q[rd_ptr_q];
  assign count     = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// CPU-writable UART transmitter: queues bytes and sends them as 8N1 frames.
// Latency: DATA write at edge N on an idle, empty block -> tx falls after N+1.
// Backpressure: none to the CPU; writes to a full FIFO are dropped, overflow set.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 180,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_io_if.slave    bus,
  output logic           tx
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          overflow_q, overflow_d;

  logic          wr_en, data_wr, ctrl_wr, rd_sel;
  logic          fifo_push_rdy, fifo_pop_vld, fifo_pop_rdy;
  logic [7:0]    fifo_pop_dat;
  logic [CW-1:0] fifo_count;
  logic [15:0]   count_ext;
  logic          fifo_full, fifo_empty, busy, bit_done;
  logic          unused_bits;

  // Bus decode
  assign wr_en   = bus.uarttxwrite & bus.uarttxcs;
  assign data_wr = wr_en & (bus.uarttxaddr == 2'b00);
  assign ctrl_wr = wr_en & (bus.uarttxaddr == 2'b10);
  assign rd_sel  = bus.uarttxread & bus.uarttxcs & (bus.uarttxaddr == 2'b10);

  // The FIFO only pops while the transmitter is idle, so a byte pushed onto
  // an empty FIFO is first popped on the following edge.
  assign fifo_pop_rdy = (state_q == S_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clock),
    .rst      (reset),
    .push_vld (data_wr),
    .push_dat (bus.uarttxwdata[7:0]),
    .push_rdy (fifo_push_rdy),
    .pop_vld  (fifo_pop_vld),
    .pop_rdy  (fifo_pop_rdy),
    .pop_dat  (fifo_pop_dat),
    .count    (fifo_count)
  );

  assign fifo_full  = ~fifo_push_rdy;
  assign fifo_empty = ~fifo_pop_vld;
  assign busy       = (state_q != S_IDLE);
  assign bit_done   = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Sticky overflow: set by a DATA write that found the FIFO full.
  always_comb begin
    overflow_d = overflow_q;
    if (data_wr && fifo_full)              overflow_d = 1'b1;
    if (ctrl_wr && bus.uarttxwdata[3])     overflow_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  // Frame FSM. tx is a flop updated together with the state so the line never
  // glitches. The shift register moves right once per bit so shreg_q[0] is
  // always the next bit to send.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (fifo_pop_vld) begin
            shreg_q <= fifo_pop_dat;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[7:1]};
            state_q   <= S_DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[0];
              shreg_q   <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

  // Status read; forced to zero while reset is held so the bus reads clean.
  assign count_ext = 16'(fifo_count);

  always_comb begin
    bus.uarttxrdata = 16'h0000;
    if (!reset && rd_sel)
      bus.uarttxrdata = {count_ext[7:0], 4'b0000, overflow_q, busy, fifo_full, fifo_empty};
  end

  assign unused_bits = ^{bus.uarttxwdata[15:8], count_ext[15:8]};
endmodule

// File: tb/tb_uart_tx_io.sv
// Testbench for uart_tx_io: directed scenarios plus random bus traffic,
// checked every cycle against a frame-level reference model.
module tb_uart_tx_io;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset;
  logic tx;

  uart_tx_io_if bus ();

  uart_tx_io #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clock = ~clock;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: a byte queue plus the edge at which the current frame
  // began. The line waveform is derived from the offset into the frame.
  logic [7:0] mq[$];
  logic       m_ovf;
  logic [7:0] m_byte;
  int         m_start;
  int         m_free;
  int         edge_no = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return (edge_no - m_start) < FRAME;
  endfunction

  function automatic logic m_tx();
    int k;
    int slot;
    k = edge_no - m_start;
    if (k >= FRAME) return 1'b1;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  function automatic logic [15:0] m_rdata();
    if (reset) return 16'h0000;
    if (bus.uarttxread && bus.uarttxcs && bus.uarttxaddr == 2'b10)
      return {8'(mq.size()), 4'b0000, m_ovf, m_busy(), (mq.size() == DEPTH), (mq.size() == 0)};
    return 16'h0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_start = -1000;
    m_free  = 0;
  endtask

  // One clock edge of the model: a waiting byte starts a frame if the line is
  // free, then a DATA write is accepted unless the queue was full before it.
  task automatic model_edge();
    logic full_before;
    edge_no++;
    if (reset) begin
      model_reset();
      return;
    end
    full_before = (mq.size() == DEPTH);
    if (edge_no >= m_free && mq.size() != 0) begin
      m_byte  = mq.pop_front();
      m_start = edge_no;
      m_free  = edge_no + FRAME + 1;
    end
    if (bus.uarttxwrite && bus.uarttxcs) begin
      if (bus.uarttxaddr == 2'b00) begin
        if (full_before) m_ovf = 1'b1;
        else             mq.push_back(bus.uarttxwdata[7:0]);
      end else if (bus.uarttxaddr == 2'b10 && bus.uarttxwdata[3]) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("tx", {15'b0, tx}, {15'b0, m_tx()});
    chk("rdata", bus.uarttxrdata, m_rdata());
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_idle();
    bus.uarttxwrite = 1'b0;
    bus.uarttxread  = 1'b1;
    bus.uarttxcs    = 1'b1;
    bus.uarttxaddr  = 2'b10;
    bus.uarttxwdata = 16'h0000;
  endtask

  task automatic do_wr(input logic cs_i, input logic [1:0] a, input logic [15:0] d);
    bus.uarttxwrite = 1'b1;
    bus.uarttxread  = 1'b0;
    bus.uarttxcs    = cs_i;
    bus.uarttxaddr  = a;
    bus.uarttxwdata = d;
    tick();
    drive_idle();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((mq.size() != 0 || m_busy()) && i < budget) begin
      tick();
      i++;
    end
    chk("drain_done", {15'b0, (mq.size() == 0 && !m_busy())}, 16'd1);
    tick();
  endtask

  // Reset pulse asserted mid-cycle, checked before any clock edge arrives.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_tx"}, {15'b0, tx}, 16'd1);
    chk({tag, "_rdata"}, bus.uarttxrdata, 16'h0000);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    reset = 1'b1;
    drive_idle();
    model_reset();
    run(3);
    chk("rst_tx", {15'b0, tx}, 16'd1);
    chk("rst_rdata", bus.uarttxrdata, 16'h0000);
    reset = 1'b0;
    tick();
    chk("idle_status", bus.uarttxrdata, 16'h0001);

    // Single frame 0x55
    do_wr(1'b1, 2'b00, 16'h0055);
    chk("t1_tx_before_pop", {15'b0, tx}, 16'd1);
    tick();
    chk("t1_tx_start", {15'b0, tx}, 16'd0);
    drain(100);
    chk("t1_status", bus.uarttxrdata, 16'h0001);

    // Three back-to-back frames
    do_wr(1'b1, 2'b00, 16'h0001);
    do_wr(1'b1, 2'b00, 16'h0080);
    do_wr(1'b1, 2'b00, 16'h00FF);
    drain(300);
    chk("t2_status", bus.uarttxrdata, 16'h0001);

    // Overflow: ten writes into an eight-entry FIFO
    for (int i = 0; i < 10; i++) do_wr(1'b1, 2'b00, 16'(i));
    #1;
    chk("t3_status", bus.uarttxrdata, 16'h080E);

    // Clear overflow while the queue drains
    do_wr(1'b1, 2'b10, 16'h0008);
    #1;
    chk("t4_status", bus.uarttxrdata, 16'h0806);
    drain(600);
    chk("t4_final", bus.uarttxrdata, 16'h0001);

    // Reset in the middle of data bit 3, with more bytes queued
    do_wr(1'b1, 2'b00, 16'h00A5);
    do_wr(1'b1, 2'b00, 16'h003C);
    do_wr(1'b1, 2'b00, 16'h000F);
    run(16);
    reset_pulse("t5");
    run(150);
    chk("t5_status", bus.uarttxrdata, 16'h0001);

    // Writes that must be ignored, and a read without IORead
    do_wr(1'b0, 2'b00, 16'h0012);
    do_wr(1'b1, 2'b01, 16'h0034);
    do_wr(1'b1, 2'b11, 16'h0056);
    bus.uarttxread = 1'b0;
    tick();
    chk("t6_noread", bus.uarttxrdata, 16'h0000);
    drive_idle();
    run(50);
    chk("t6_tx", {15'b0, tx}, 16'd1);
    chk("t6_status", bus.uarttxrdata, 16'h0001);

    // Random bus traffic
    repeat (800) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        do_wr(1'b1, 2'b00, 16'($urandom_range(0, 65535)));
      end else if (r < 34) begin
        do_wr(1'b1, 2'b10, 16'($urandom_range(0, 65535)));
      end else if (r < 40) begin
        do_wr(1'b0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
      end else if (r < 45) begin
        do_wr(1'b1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, 16'($urandom_range(0, 65535)));
      end else if (r < 46) begin
        reset_pulse("rnd_rst");
      end else begin
        bus.uarttxwrite = 1'b0;
        bus.uarttxread  = 1'($urandom_range(0, 1));
        bus.uarttxcs    = 1'($urandom_range(0, 1));
        bus.uarttxaddr  = 2'($urandom_range(0, 3));
        bus.uarttxwdata = 16'($urandom_range(0, 65535));
        tick();
      end
    end
    drive_idle();
    drain(1000);
    chk("rnd_final", bus.uarttxrdata, {8'h00, 4'b0000, m_ovf, 3'b001});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
